// File: rtl/lsu.sv
// ============================================================================
// lsu : memory-access stage; one bus transaction per instruction, load format
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu #(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_result,
    input  logic [63:0] in_wdata,
    input  logic [1:0]  in_memop,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [4:0]  in_rd,
    output logic        dreq_valid,
    output logic        dreq_write,
    output logic [63:0] dreq_addr,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_wdata,
    input  logic        dresp_ok,
    input  logic [63:0] dresp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        dreq_valid_q;
    logic        dreq_write_q;
    logic [63:0] dreq_addr_q;
    logic [7:0]  dreq_strobe_q;
    logic [63:0] dreq_wdata_q;
    logic        out_valid_q;
    logic [63:0] out_data_q;
    logic [4:0]  out_rd_q;
    logic        out_wen_q;
    logic        out_misalign_q;

    logic        w_is_mem;
    logic        w_misalign;
    logic [7:0]  w_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_load;

    assign in_ready = (state_q == IDLE);

    always_comb begin
        w_is_mem   = (in_memop == 2'd1) || (in_memop == 2'd2);
        w_misalign = 1'b0;
        w_mask     = 8'h01;
        case (in_size)
            2'd0: begin w_mask = 8'h01; w_misalign = 1'b0;                    end
            2'd1: begin w_mask = 8'h03; w_misalign = in_result[0];            end
            2'd2: begin w_mask = 8'h0F; w_misalign = |in_result[1:0];         end
            default: begin w_mask = 8'hFF; w_misalign = |in_result[2:0];      end
        endcase
    end

    // Response arrives as an aligned doubleword; bring the addressed lane to bit 0.
    always_comb begin
        w_shifted = dresp_rdata >> {lo_q, 3'b000};
        w_load    = w_shifted;
        case (size_q)
            2'd0: w_load = uns_q ? {56'd0, w_shifted[7:0]}
                                 : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_load = uns_q ? {48'd0, w_shifted[15:0]}
                                 : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_load = uns_q ? {32'd0, w_shifted[31:0]}
                                 : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            lo_q           <= 3'd0;
            size_q         <= 2'd0;
            uns_q          <= 1'b0;
            dreq_valid_q   <= 1'b0;
            dreq_write_q   <= 1'b0;
            dreq_addr_q    <= 64'd0;
            dreq_strobe_q  <= 8'd0;
            dreq_wdata_q   <= 64'd0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 64'd0;
            out_rd_q       <= 5'd0;
            out_wen_q      <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        lo_q     <= in_result[2:0];
                        size_q   <= in_size;
                        uns_q    <= in_unsigned;
                        out_rd_q <= in_rd;
                        if (!w_is_mem) begin
                            state_q        <= DONE;
                            out_valid_q    <= 1'b1;
                            out_data_q     <= in_result;
                            out_wen_q      <= 1'b1;
                            out_misalign_q <= 1'b0;
                        end else if (MISALIGN_CHECK && w_misalign) begin
                            state_q        <= DONE;
                            out_valid_q    <= 1'b1;
                            out_data_q     <= in_result;
                            out_wen_q      <= 1'b0;
                            out_misalign_q <= 1'b1;
                        end else begin
                            state_q        <= BUS;
                            dreq_valid_q   <= 1'b1;
                            dreq_write_q   <= (in_memop == 2'd2);
                            dreq_addr_q    <= {in_result[63:3], 3'b000};
                            dreq_strobe_q  <= w_mask << in_result[2:0];
                            dreq_wdata_q   <= in_wdata << {in_result[2:0], 3'b000};
                            out_misalign_q <= 1'b0;
                        end
                    end
                end
                BUS: begin
                    if (dresp_ok) begin
                        state_q      <= DONE;
                        dreq_valid_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_data_q   <= dreq_write_q ? 64'd0 : w_load;
                        out_wen_q    <= !dreq_write_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dreq_valid   = dreq_valid_q;
    assign dreq_write   = dreq_write_q;
    assign dreq_addr    = dreq_addr_q;
    assign dreq_strobe  = dreq_strobe_q;
    assign dreq_wdata   = dreq_wdata_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_rd       = out_rd_q;
    assign out_wen      = out_wen_q;
    assign out_misalign = out_misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// tb_lsu : table-driven directed checks for lsu plus multi-cycle corner cases
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_valid1;
    logic [63:0] in_result, in_wdata;
    logic [1:0]  in_memop, in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        dresp_ok;
    logic [63:0] dresp_rdata;
    logic        out_ready;

    logic        in_ready, dreq_valid, dreq_write, out_valid, out_wen, out_misalign;
    logic [63:0] dreq_addr, dreq_wdata, out_data;
    logic [7:0]  dreq_strobe;
    logic [4:0]  out_rd;

    logic        in_ready1, dreq_valid1, dreq_write1, out_valid1, out_wen1, out_misalign1;
    logic [63:0] dreq_addr1, dreq_wdata1, out_data1;
    logic [7:0]  dreq_strobe1;
    logic [4:0]  out_rd1;

    int n_tests = 0;
    int n_fail  = 0;

    lsu #(.MISALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_wdata(in_wdata), .in_memop(in_memop),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata), .dresp_ok(dresp_ok),
        .dresp_rdata(dresp_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_wen(out_wen),
        .out_misalign(out_misalign)
    );

    lsu #(.MISALIGN_CHECK(1'b0)) u_dut_nochk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_result(in_result), .in_wdata(in_wdata), .in_memop(in_memop),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
        .dreq_valid(dreq_valid1), .dreq_write(dreq_write1), .dreq_addr(dreq_addr1),
        .dreq_strobe(dreq_strobe1), .dreq_wdata(dreq_wdata1), .dresp_ok(dresp_ok),
        .dresp_rdata(dresp_rdata), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_rd(out_rd1), .out_wen(out_wen1),
        .out_misalign(out_misalign1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [63:0] result;
        logic [63:0] wdata;
        logic [1:0]  memop;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic [63:0] rdata;
        int          waitc;
        logic        bus;
        logic [63:0] e_addr;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;
        logic        e_write;
        logic [63:0] e_data;
        logic        e_wen;
        logic        e_mis;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        chk($sformatf("v%0d.in_ready", idx), 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_result   = v.result;
        in_wdata    = v.wdata;
        in_memop    = v.memop;
        in_size     = v.size;
        in_unsigned = v.uns;
        in_rd       = v.rd;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (v.bus) begin
            for (int i = 0; i <= v.waitc; i++) begin
                @(negedge clk);
                chk($sformatf("v%0d.dreq_valid[%0d]", idx, i), 64'(dreq_valid), 64'd1);
                chk($sformatf("v%0d.dreq_addr[%0d]", idx, i), dreq_addr, v.e_addr);
                chk($sformatf("v%0d.dreq_strobe[%0d]", idx, i), 64'(dreq_strobe), 64'(v.e_strb));
                chk($sformatf("v%0d.dreq_wdata[%0d]", idx, i), dreq_wdata, v.e_wdata);
                chk($sformatf("v%0d.dreq_write[%0d]", idx, i), 64'(dreq_write), 64'(v.e_write));
                chk($sformatf("v%0d.busy_out_valid[%0d]", idx, i), 64'(out_valid), 64'd0);
            end
            dresp_ok    = 1'b1;
            dresp_rdata = v.rdata;
            @(posedge clk);
            #1;
            dresp_ok    = 1'b0;
            dresp_rdata = 64'd0;
        end
        @(negedge clk);
        chk($sformatf("v%0d.out_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d.dreq_valid_off", idx), 64'(dreq_valid), 64'd0);
        chk($sformatf("v%0d.out_data", idx), out_data, v.e_data);
        chk($sformatf("v%0d.out_wen", idx), 64'(out_wen), 64'(v.e_wen));
        chk($sformatf("v%0d.out_misalign", idx), 64'(out_misalign), 64'(v.e_mis));
        chk($sformatf("v%0d.out_rd", idx), 64'(out_rd), 64'(v.rd));
        @(negedge clk);
        chk($sformatf("v%0d.out_valid_drop", idx), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d.in_ready_back", idx), 64'(in_ready), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{64'h1234, 64'h0, 2'd0, 2'd0, 1'b0, 5'd1, 64'h0, 0, 1'b0,
                     64'h0, 8'h00, 64'h0, 1'b0, 64'h1234, 1'b1, 1'b0};
        vecs[1]  = '{64'h1003, 64'h0, 2'd1, 2'd0, 1'b0, 5'd2, 64'h0000_0000_8000_0000, 3, 1'b1,
                     64'h1000, 8'h08, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0};
        vecs[2]  = '{64'h1003, 64'h0, 2'd1, 2'd0, 1'b1, 5'd3, 64'h0000_0000_8000_0000, 3, 1'b1,
                     64'h1000, 8'h08, 64'h0, 1'b0, 64'h80, 1'b1, 1'b0};
        vecs[3]  = '{64'h2004, 64'hDEAD_BEEF, 2'd2, 2'd2, 1'b0, 5'd4, 64'h0, 0, 1'b1,
                     64'h2000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b1, 64'h0, 1'b0, 1'b0};
        vecs[4]  = '{64'h3001, 64'h0, 2'd1, 2'd1, 1'b0, 5'd5, 64'h0, 0, 1'b0,
                     64'h0, 8'h00, 64'h0, 1'b0, 64'h3001, 1'b0, 1'b1};
        vecs[5]  = '{64'h55, 64'h0, 2'd3, 2'd0, 1'b0, 5'd6, 64'h0, 0, 1'b0,
                     64'h0, 8'h00, 64'h0, 1'b0, 64'h55, 1'b1, 1'b0};
        vecs[6]  = '{64'h4000, 64'h0, 2'd1, 2'd3, 1'b0, 5'd7, 64'h8123_4567_89AB_CDEF, 1, 1'b1,
                     64'h4000, 8'hFF, 64'h0, 1'b0, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b0};
        vecs[7]  = '{64'h5006, 64'h0, 2'd1, 2'd1, 1'b0, 5'd8, 64'h8001_0000_0000_0000, 0, 1'b1,
                     64'h5000, 8'hC0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0};
        vecs[8]  = '{64'h6004, 64'h0, 2'd1, 2'd2, 1'b1, 5'd9, 64'hF000_0001_0000_0000, 2, 1'b1,
                     64'h6000, 8'hF0, 64'h0, 1'b0, 64'hF000_0001, 1'b1, 1'b0};
        vecs[9]  = '{64'h7002, 64'h0, 2'd2, 2'd2, 1'b0, 5'd10, 64'h0, 0, 1'b0,
                     64'h0, 8'h00, 64'h0, 1'b0, 64'h7002, 1'b0, 1'b1};
        vecs[10] = '{64'h8004, 64'h0, 2'd1, 2'd3, 1'b0, 5'd11, 64'h0, 0, 1'b0,
                     64'h0, 8'h00, 64'h0, 1'b0, 64'h8004, 1'b0, 1'b1};
        vecs[11] = '{64'h9005, 64'hFFFF_FFFF_FFFF_FF5A, 2'd2, 2'd0, 1'b0, 5'd12, 64'h0, 0, 1'b1,
                     64'h9000, 8'h20, 64'hFFFF_5A00_0000_0000, 1'b1, 64'h0, 1'b0, 1'b0};
        vecs[12] = '{64'hB000, 64'h0, 2'd1, 2'd2, 1'b0, 5'd13, 64'h0000_0000_8000_0001, 0, 1'b1,
                     64'hB000, 8'h0F, 64'h0, 1'b0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        in_result = '0; in_wdata = '0; in_memop = '0; in_size = '0;
        in_unsigned = 1'b0; in_rd = '0; dresp_ok = 1'b0; dresp_rdata = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.dreq_valid", 64'(dreq_valid), 64'd0);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.out_wen", 64'(out_wen), 64'd0);
        chk("reset.out_misalign", 64'(out_misalign), 64'd0);
        chk("reset.out_data", out_data, 64'd0);
        chk("reset.dreq_addr", dreq_addr, 64'd0);
        chk("reset.dreq_strobe", 64'(dreq_strobe), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Backpressure, then a request held across the handshake edge
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 64'hABCD; in_memop = 2'd0; in_rd = 5'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp.out_valid[%0d]", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp.out_data[%0d]", i), out_data, 64'hABCD);
            chk($sformatf("bp.out_rd[%0d]", i), 64'(out_rd), 64'd7);
            chk($sformatf("bp.in_ready[%0d]", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_result = 64'h77; in_rd = 5'd8;
        @(negedge clk);
        chk("bp.in_ready_rise", 64'(in_ready), 64'd1);
        chk("bp.out_valid_fall", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp.next_out_valid", 64'(out_valid), 64'd1);
        chk("bp.next_out_data", out_data, 64'h77);
        @(negedge clk);

        // Reset while a bus request is outstanding; a late response must be ignored
        in_valid = 1'b1; in_result = 64'hA000; in_memop = 2'd1; in_size = 2'd3; in_rd = 5'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rst.dreq_valid_before", 64'(dreq_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        dresp_ok = 1'b1; dresp_rdata = 64'h1111_2222_3333_4444;
        @(posedge clk);
        #1 dresp_ok = 1'b0; dresp_rdata = '0;
        @(negedge clk);
        chk("rst.late_out_valid", 64'(out_valid), 64'd0);
        chk("rst.late_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst.late_in_ready", 64'(in_ready), 64'd1);

        // Misaligned half with the check disabled still goes to the bus
        in_valid1 = 1'b1; in_result = 64'h3001; in_memop = 2'd1; in_size = 2'd1;
        in_unsigned = 1'b0; in_rd = 5'd14;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        chk("nochk.dreq_valid", 64'(dreq_valid1), 64'd1);
        chk("nochk.dreq_addr", dreq_addr1, 64'h3000);
        chk("nochk.dreq_strobe", 64'(dreq_strobe1), 64'h06);
        chk("nochk.checked_inst_idle", 64'(dreq_valid), 64'd0);
        dresp_ok = 1'b1; dresp_rdata = 64'h0000_0000_00AB_CD00;
        @(posedge clk);
        #1 dresp_ok = 1'b0; dresp_rdata = '0;
        @(negedge clk);
        chk("nochk.out_valid", 64'(out_valid1), 64'd1);
        chk("nochk.out_data", out_data1, 64'hFFFF_FFFF_FFFF_ABCD);
        chk("nochk.out_misalign", 64'(out_misalign1), 64'd0);
        chk("nochk.out_wen", 64'(out_wen1), 64'd1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Takes the ALU result (effective address, or the final result for non-memory ops) plus store data and memory-op control.
- Performs at most one data-bus transaction per instruction and formats load data.
- Hands a single result to writeback over a valid/ready handshake.

Parameters:
- MISALIGN_CHECK, 1: when 1, misaligned accesses raise out_misalign and issue no bus request; when 0, the address is passed to the bus unchecked.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  LSU can accept an instruction
- in_result  in  64  ALU output; address for memory ops, result otherwise
- in_wdata  in  64  store data, low bits significant
- in_memop  in  2  0=none, 1=load, 2=store, 3=reserved (treated as none)
- in_size  in  2  0=byte, 1=half, 2=word, 3=double
- in_unsigned  in  1  load zero-extends when 1
- in_rd  in  5  destination register tag
- dreq_valid  out  1  bus request
- dreq_write  out  1  1=store
- dreq_addr  out  64  address, low 3 bits cleared
- dreq_strobe  out  8  byte enables
- dreq_wdata  out  64  lane-shifted store data
- dresp_ok  in  1  request accepted and completed this cycle
- dresp_rdata  in  64  aligned 8-byte read data, valid with dresp_ok
- out_valid  out  1  result to writeback
- out_ready  in  1  writeback accepts
- out_data  out  64  result
- out_rd  out  5  destination tag
- out_wen  out  1  register write required (0 for stores and misaligned ops)
- out_misalign  out  1  access fault flag

Behaviour:
- Clock is clk; reset is synchronous, active-low (rst_n), sampled on the rising edge of clk.
- Reset:
  - state=IDLE.
  - dreq_valid, out_valid, out_wen and out_misalign are 0.
  - out_data, out_rd, dreq_addr, dreq_strobe and dreq_wdata are 0.
  - Reset mid-transaction drops dreq_valid on that same edge; the in-flight instruction is discarded.
- States are IDLE, BUS, DONE.
- in_ready = (state==IDLE). This is combinational from state only.
- Acceptance happens when in_valid & in_ready on an edge. All inputs are latched at acceptance.
- Non-memory op: go to DONE.
  - out_data = in_result, out_wen = 1.
  - out_valid rises the next cycle (latency 1).
- Misaligned memory op (MISALIGN_CHECK=1): go to DONE with out_misalign=1, out_wen=0, out_data=address. No bus request is made.
  - Half is misaligned when addr[0]!=0.
  - Word is misaligned when addr[1:0]!=0.
  - Double is misaligned when addr[2:0]!=0.
- Aligned memory op: go to BUS. dreq_valid=1 from the cycle after acceptance.
  - dreq_addr = {addr[63:3],3'b0}.
  - dreq_strobe = size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0].
  - dreq_wdata = in_wdata shifted left by 8*addr[2:0].
  - dreq_write = store.
  - All dreq_* outputs stay stable until dresp_ok.
- In BUS with dresp_ok high: dreq_valid falls on the next edge and the state moves to DONE.
  - Load: out_data = dresp_rdata >> 8*addr[2:0], truncated to size, then sign- or zero-extended per in_unsigned (double ignores in_unsigned). out_wen=1.
  - Store: out_data=0, out_wen=0.
- dresp_ok outside BUS is ignored.
- In DONE: out_valid=1 with out_* held stable. On out_valid & out_ready the state returns to IDLE and out_valid falls. No new instruction is accepted in that same cycle.
- Maximum throughput is one instruction per 2 cycles for non-memory ops and 3 cycles for memory ops with zero-wait dresp_ok.

Test Plan:
- Non-memory op: in_result=0x1234, in_memop=0, out_ready=1 -> out_valid one cycle after acceptance, out_data=0x1234, out_wen=1, dreq_valid never asserted.
- Signed byte load: addr=0x1003, size=0, unsigned=0, dresp_rdata=0x00000000_80000000 returned after 3 wait cycles.
  - During the wait: dreq_addr=0x1000, strobe=0x08, held stable.
  - Result: out_data=0xFFFFFFFFFFFFFF80.
  - Repeat with unsigned=1 -> out_data=0x80.
- Word store: addr=0x2004, wdata=0xDEADBEEF -> strobe=0xF0, dreq_wdata=0xDEADBEEF_00000000, dreq_write=1, out_wen=0.
- Misaligned half: addr=0x3001, size=1 -> no dreq_valid, out_misalign=1, out_data=0x3001. Repeat with MISALIGN_CHECK=0 -> a bus request is issued.
- Backpressure: hold out_ready=0 for 5 cycles -> out_* stable, in_ready=0. Then out_ready=1 -> in_ready rises the following cycle.
- Reset mid-BUS: rst_n low while dreq_valid=1 -> next edge dreq_valid=0, out_valid=0, in_ready=1 after release. A late dresp_ok is ignored.
